// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// sdram_arbiter : round-robin share of one Avalon-MM SDRAM port, one txn in flight
// Revision      : 1.0
// ============================================================================
module sdram_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [NREQ-1:0]    m_waitrequest,
    input  logic [NREQ*AW-1:0] m_address,
    input  logic [NREQ-1:0]    m_read,
    output logic [DW-1:0]      m_readdata,
    output logic [NREQ-1:0]    m_readdatavalid,
    input  logic [NREQ-1:0]    m_write,
    input  logic [NREQ*DW-1:0] m_writedata,
    input  logic               s_waitrequest,
    output logic [AW-1:0]      s_address,
    output logic               s_read,
    input  logic [DW-1:0]      s_readdata,
    input  logic               s_readdatavalid,
    output logic               s_write,
    output logic [DW-1:0]      s_writedata,
    output logic               busy
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT_RD = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic [GW-1:0]   last_q, last_d;
    logic [NREQ-1:0] req;
    logic            found;
    int              idx;

    assign req = m_read | m_write;

    // rst_n is an active-high reset despite its name
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= GW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        found   = 1'b0;
        idx     = 0;
        case (state_q)
            IDLE: begin
                // search starts just after the last served requester
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (int'(last_q) + k) % NREQ;
                    if (!found && req[idx]) begin
                        found = 1'b1;
                        gnt_d = GW'(idx);
                    end
                end
                if (found) state_d = ISSUE;
            end
            ISSUE: begin
                if (!s_waitrequest && m_read[gnt_q]) begin
                    state_d = WAIT_RD;
                    last_d  = gnt_q;
                end else if (!s_waitrequest && m_write[gnt_q]) begin
                    state_d = IDLE;
                    last_d  = gnt_q;
                end else if (!m_read[gnt_q] && !m_write[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            WAIT_RD: begin
                if (s_readdatavalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_waitrequest   = '1;
        m_readdatavalid = '0;
        m_readdata      = s_readdata;
        s_address       = '0;
        s_writedata     = '0;
        s_read          = 1'b0;
        s_write         = 1'b0;
        busy            = (state_q != IDLE);
        case (state_q)
            ISSUE: begin
                s_address            = m_address[int'(gnt_q)*AW +: AW];
                s_writedata          = m_writedata[int'(gnt_q)*DW +: DW];
                s_read               = m_read[gnt_q];
                s_write              = m_write[gnt_q] & ~m_read[gnt_q];
                m_waitrequest[gnt_q] = s_waitrequest;
            end
            WAIT_RD: begin
                // owner sees no wait so a hold-until-data master completes cleanly
                m_waitrequest[gnt_q]   = 1'b0;
                m_readdatavalid[gnt_q] = s_readdatavalid;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sdram_arbiter : directed bench with a transaction-level reference model
// Revision         : 1.0
// ============================================================================
module tb_sdram_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    m_waitrequest;
    logic [NREQ*AW-1:0] m_address;
    logic [NREQ-1:0]    m_read;
    logic [DW-1:0]      m_readdata;
    logic [NREQ-1:0]    m_readdatavalid;
    logic [NREQ-1:0]    m_write;
    logic [NREQ*DW-1:0] m_writedata;
    logic               s_waitrequest;
    logic [AW-1:0]      s_address;
    logic               s_read;
    logic [DW-1:0]      s_readdata;
    logic               s_readdatavalid;
    logic               s_write;
    logic [DW-1:0]      s_writedata;
    logic               busy;

    int vectors     = 0;
    int miscompares = 0;
    int rd_issued   = 0;

    sdram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .m_waitrequest   (m_waitrequest),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .s_waitrequest   (s_waitrequest),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: owner = requester holding the port (-1 none),
    // reading = its read was accepted and data is outstanding.
    int owner   = -1;
    bit reading = 1'b0;
    int last    = NREQ - 1;
    int cand;

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            owner   = -1;
            reading = 1'b0;
            last    = NREQ - 1;
        end else if (owner < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = (last + k) % NREQ;
                if (owner < 0 && (m_read[cand] || m_write[cand])) owner = cand;
            end
        end else if (!reading) begin
            if (!s_waitrequest && m_read[owner]) begin
                reading = 1'b1;
                last    = owner;
            end else if (!s_waitrequest && m_write[owner]) begin
                last  = owner;
                owner = -1;
            end else if (!m_read[owner] && !m_write[owner]) begin
                owner = -1;
            end
        end else if (s_readdatavalid) begin
            reading = 1'b0;
            owner   = -1;
        end
    end

    logic [NREQ-1:0] e_wreq, e_rdv;
    logic            e_srd, e_swr;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wd;

    always @(negedge clk) begin
        e_wreq = '1;
        e_rdv  = '0;
        e_srd  = 1'b0;
        e_swr  = 1'b0;
        e_addr = '0;
        e_wd   = '0;
        if (owner >= 0) begin
            if (reading) begin
                e_wreq[owner] = 1'b0;
                e_rdv[owner]  = s_readdatavalid;
            end else begin
                e_wreq[owner] = s_waitrequest;
                e_srd         = m_read[owner];
                e_swr         = m_write[owner] && !m_read[owner];
                e_addr        = m_address[owner*AW +: AW];
                e_wd          = m_writedata[owner*DW +: DW];
            end
        end
        check("m_waitrequest",   64'(m_waitrequest),   64'(e_wreq));
        check("m_readdatavalid", 64'(m_readdatavalid), 64'(e_rdv));
        check("m_readdata",      64'(m_readdata),      64'(s_readdata));
        check("s_read",          64'(s_read),          64'(e_srd));
        check("s_write",         64'(s_write),         64'(e_swr));
        check("s_address",       64'(s_address),       64'(e_addr));
        check("s_writedata",     64'(s_writedata),     64'(e_wd));
        check("busy",            64'(busy),            64'(owner >= 0));
        if (s_read && !s_waitrequest) rd_issued++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int grants[8];
    int ngr;
    int g;
    int acc;
    bit done;
    int rd_base;

    initial begin
        rst_n           = 1'b1;
        m_read          = '0;
        m_write         = '0;
        m_address       = '0;
        m_writedata     = '0;
        s_waitrequest   = 1'b0;
        s_readdata      = '0;
        s_readdatavalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("reset_waitreq", 64'(m_waitrequest), 64'h3);
        check("reset_busy",    64'(busy),          64'h0);

        // single write from requester 0
        tick();
        m_write = 2'b01; m_address[31:0] = 32'h100; m_writedata[31:0] = 32'hDEADBEEF;
        @(negedge clk);
        check("t1_idle_no_cmd", 64'(s_write), 64'h0);
        tick();
        @(negedge clk);
        check("t1_s_write", 64'(s_write),       64'h1);
        check("t1_addr",    64'(s_address),     64'h100);
        check("t1_data",    64'(s_writedata),   64'hDEADBEEF);
        check("t1_waitreq", 64'(m_waitrequest), 64'h2);
        tick();
        m_write = '0;
        @(negedge clk);
        check("t1_idle_after", 64'(busy), 64'h0);

        // read from requester 1, data three cycles after acceptance
        tick();
        m_read = 2'b10; m_address[63:32] = 32'h40;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("t2_s_read",  64'(s_read),        64'h1);
        check("t2_addr",    64'(s_address),     64'h40);
        check("t2_waitreq", 64'(m_waitrequest), 64'h1);
        tick();
        m_read = '0;
        @(negedge clk);
        check("t2_wait_busy", 64'(busy), 64'h1);
        tick();
        @(negedge clk);
        check("t2_no_rdv_yet", 64'(m_readdatavalid), 64'h0);
        tick();
        s_readdatavalid = 1'b1; s_readdata = 32'h1234;
        @(negedge clk);
        check("t2_rdv",      64'(m_readdatavalid), 64'h2);
        check("t2_readdata", 64'(m_readdata),      64'h1234);
        tick();
        s_readdatavalid = 1'b0;
        @(negedge clk);
        check("t2_rdv_once", 64'(m_readdatavalid), 64'h0);

        // both requesters writing back to back: grants alternate
        tick();
        m_write = 2'b11; m_writedata = {32'h11111111, 32'h00000000};
        ngr = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (s_write && ngr < 8) begin
                g = -1;
                for (int j = 0; j < NREQ; j++) if (!m_waitrequest[j]) g = j;
                grants[ngr] = g;
                ngr++;
            end
            tick();
        end
        m_write = '0;
        check("t3_ngrants", 64'(ngr), 64'd4);
        check("t3_g0", 64'(grants[0]), 64'd0);
        check("t3_g1", 64'(grants[1]), 64'd1);
        check("t3_g2", 64'(grants[2]), 64'd0);
        check("t3_g3", 64'(grants[3]), 64'd1);

        // slave stalls four cycles; other requester held off throughout
        m_write = 2'b11; m_address[31:0] = 32'h200; m_writedata[31:0] = 32'hA5A5A5A5;
        s_waitrequest = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("t4_stall_write", 64'(s_write),       64'h1);
            check("t4_stall_addr",  64'(s_address),     64'h200);
            check("t4_stall_data",  64'(s_writedata),   64'hA5A5A5A5);
            check("t4_stall_wreq",  64'(m_waitrequest), 64'h3);
        end
        tick();
        s_waitrequest = 1'b0;
        @(negedge clk);
        check("t4_accept_wreq", 64'(m_waitrequest), 64'h2);
        tick();
        m_write = 2'b10;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("t4_other_served", 64'(m_waitrequest), 64'h1);
        check("t4_other_addr",   64'(s_address),     64'h40);
        tick();
        m_write = '0;

        // reset while a read is outstanding, then a stray readdatavalid
        m_read = 2'b01; m_address[31:0] = 32'h300;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("t5_s_read", 64'(s_read), 64'h1);
        tick();
        m_read = '0;
        @(negedge clk);
        check("t5_wait_busy", 64'(busy), 64'h1);
        tick();
        rst_n = 1'b1; s_readdatavalid = 1'b1;
        @(negedge clk);
        check("t5_rst_busy", 64'(busy),            64'h0);
        check("t5_rst_rdv",  64'(m_readdatavalid), 64'h0);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_stray_rdv", 64'(m_readdatavalid), 64'h0);
        tick();
        s_readdatavalid = 1'b0; m_write = 2'b11;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("t5_grant0_after_rst", 64'(m_waitrequest), 64'h2);
        tick();
        m_write = '0;

        // requester 1 holds read until readdatavalid with waitrequest low
        rd_base = rd_issued;
        for (int w = 0; w < 2; w++) begin
            m_read = 2'b10;
            m_address[63:32] = 32'h1000 + 32'(4 * w);
            acc  = -1;
            done = 1'b0;
            for (int n = 0; n < 20 && !done; n++) begin
                @(negedge clk);
                if (s_read && !s_waitrequest) acc = 0;
                if (m_readdatavalid[1] && !m_waitrequest[1]) begin
                    done = 1'b1;
                    check("t6_word_data", 64'(m_readdata), 64'hC0DE0000 + 64'(w));
                end
                tick();
                if (done) begin
                    m_read = '0;
                    s_readdatavalid = 1'b0;
                end else if (acc >= 0) begin
                    acc++;
                    s_readdatavalid = (acc == 2);
                    s_readdata      = 32'hC0DE0000 + 32'(w);
                end
            end
            if (!done) check("t6_word_timeout", 64'h0, 64'h1);
        end
        @(negedge clk);
        tick();
        check("t6_reads_issued", 64'(rd_issued - rd_base), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
